// File: rtl/core_mem_sequencer_if.sv
// Shared single-port memory bus between the core sequencer (master) and memory (slave).
// One transfer is outstanding at a time; bus_ack completes it and qualifies bus_rdata.
interface core_mem_sequencer_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/core_mem_sequencer.sv
// Multi-cycle sequencer that lets a single-cycle datapath share one memory bus between
// instruction fetch and load/store. It latches the fetched instruction and the load word,
// commits exactly one instruction per sequence, traps misaligned data accesses and bus
// timeouts into a sticky fault, and counts retired instructions.
module core_mem_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] pc,
  input  logic [31:0] alu_res,
  input  logic [31:0] write_data,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_reg_we,
  input  logic [2:0]  mem_ctrl,
  output logic [31:0] instr,
  output logic        dp_en,
  output logic        dp_reg_we,
  output logic [31:0] ram_rdata_q,
  core_mem_sequencer_if.master bus,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] retired
);

  // Wide enough to hold TIMEOUT-1, the last wait count before a timeout fires.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_e;

  state_e        state_q;
  logic [31:0]   instr_q;
  logic [31:0]   rdata_q;
  logic [31:0]   retired_q;
  logic [31:0]   fault_addr_q;
  logic [1:0]    cause_q;
  logic [CW-1:0] wait_q;

  logic        in_fetch;
  logic        in_mem;
  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        commit;
  logic        timeout_hit;
  logic [31:0] req_addr;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic        unused_ok;

  assign in_fetch = (state_q == S_FETCH);
  assign in_mem   = (state_q == S_MEM);
  assign mem_op   = dec_mem_read | dec_mem_write;

  // Size 11 is treated as a word access.
  assign is_half    = (mem_ctrl[1:0] == 2'b01);
  assign is_word    = mem_ctrl[1];
  assign misaligned = (is_half & alu_res[0]) | (is_word & (alu_res[1:0] != 2'b00));

  // Both addresses come straight from the datapath, which holds them stable for the whole
  // transfer: pc only moves at commit and alu_res is settled by the end of EXEC.
  assign req_addr = in_fetch ? {pc[31:2], 2'b00} : {alu_res[31:2], 2'b00};

  // Ack on the last permitted cycle still completes the transfer.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1)) && !bus.bus_ack;

  // Commit happens in EXEC for non-memory instructions and in WB for loads/stores.
  assign commit    = ((state_q == S_EXEC) && !mem_op) || (state_q == S_WB);
  assign dp_en     = commit;
  assign dp_reg_we = commit & dec_reg_we;

  assign instr       = instr_q;
  assign ram_rdata_q = rdata_q;
  assign retired     = retired_q;
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = cause_q;
  assign fault_addr  = fault_addr_q;

  // Low pc bits are implied zero on the bus; the unsigned-load flag belongs to the datapath.
  assign unused_ok = ^{pc[1:0], mem_ctrl[2]};

  // Store lane steering: replicate the operand across lanes, enable only the addressed bytes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    store_be    = 4'hF;
    store_wdata = write_data;
    case (mem_ctrl[1:0])
      2'b00: begin
        store_be    = 4'b0001 << alu_res[1:0];
        store_wdata = {4{write_data[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << alu_res[1:0];
        store_wdata = {2{write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus outputs decoded from state; all bus outputs idle at zero outside FETCH/MEM.
  always_comb begin
    bus.bus_req   = in_fetch | in_mem;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'h0;
    bus.bus_be    = 4'h0;
    bus.bus_wdata = 32'h0;
    if (in_fetch) begin
      bus.bus_addr = req_addr;
      bus.bus_be   = 4'hF;
    end else if (in_mem) begin
      bus.bus_addr  = req_addr;
      bus.bus_we    = dec_mem_write;
      bus.bus_be    = dec_mem_write ? store_be : 4'hF;
      bus.bus_wdata = dec_mem_write ? store_wdata : 32'h0;
    end
  end

  // Sequencer FSM with its latched instruction/load word, wait counter, fault record and count.
  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      instr_q      <= NOP;
      rdata_q      <= 32'h0;
      retired_q    <= 32'h0;
      fault_addr_q <= 32'h0;
      cause_q      <= 2'b00;
      wait_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
          end
        end
        S_FETCH: begin
          if (bus.bus_ack) begin
            instr_q <= bus.bus_rdata;
            state_q <= S_EXEC;
          end else if (timeout_hit) begin
            state_q      <= S_FAULT;
            cause_q      <= 2'b01;
            fault_addr_q <= req_addr;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_EXEC: begin
          if (!mem_op) begin
            retired_q <= retired_q + 32'd1;
            state_q   <= run ? S_FETCH : S_IDLE;
            wait_q    <= '0;
          end else if (misaligned) begin
            state_q      <= S_FAULT;
            cause_q      <= 2'b11;
            fault_addr_q <= alu_res;
          end else begin
            state_q <= S_MEM;
            wait_q  <= '0;
          end
        end
        S_MEM: begin
          if (bus.bus_ack) begin
            if (dec_mem_read) rdata_q <= bus.bus_rdata;
            state_q <= S_WB;
          end else if (timeout_hit) begin
            state_q      <= S_FAULT;
            cause_q      <= 2'b10;
            fault_addr_q <= req_addr;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WB: begin
          retired_q <= retired_q + 32'd1;
          state_q   <= run ? S_FETCH : S_IDLE;
          wait_q    <= '0;
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
